// File: rtl/serializer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serializer_arbiter
// Purpose  : Round-robin scheduler sharing one 16-bit MSB-first serializer
//            between N_REQ requesters. Takes one word per valid/ready
//            handshake. Drops words whose data_mod the serializer ignores
//            (1, 2). Issues all other words as a one-cycle data_val pulse,
//            then tracks serializer busy until the transfer completes.
// Revision : 1.0  initial release
// ============================================================================
module serializer_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic [N_REQ*16-1:0]        req_data_i,
    input  logic [N_REQ*4-1:0]         req_mod_i,
    input  logic [N_REQ-1:0]           req_val_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [15:0]                ser_data_o,
    output logic [3:0]                 ser_mod_o,
    output logic                       ser_val_o,
    input  logic                       ser_busy_i,
    output logic [$clog2(N_REQ)-1:0]   grant_id_o,
    output logic                       active_o,
    output logic                       drop_o,
    output logic                       timeout_o
);

    localparam int c_ID_W  = $clog2(N_REQ);
    localparam int c_CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_ID_W-1:0]     r_ptr;
    logic [c_ID_W-1:0]     r_grant_id;
    logic [15:0]           r_data;
    logic [3:0]            r_mod;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_drop;

    logic [15:0]           w_data_arr [N_REQ];
    logic [3:0]            w_mod_arr  [N_REQ];
    logic                  w_found;
    logic [c_ID_W-1:0]     w_winner;
    logic                  w_grant;
    logic                  w_is_drop;
    logic                  w_timeout;

    // Split the flat requester buses into per-requester words
    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_data_arr[g] = req_data_i[16*g +: 16];
            assign w_mod_arr[g]  = req_mod_i[4*g +: 4];
        end
    endgenerate

    // Round-robin search: first valid requester after the last one served
    always_comb begin : p_search
        int                v_idx;
        logic [c_ID_W-1:0] v_sel;
        v_idx    = 0;
        v_sel    = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            v_idx = (int'(r_ptr) + i) % N_REQ;
            v_sel = c_ID_W'(v_idx);
            if (!w_found && req_val_i[v_sel]) begin
                w_found  = 1'b1;
                w_winner = v_sel;
            end
        end
    end

    // A handshake happens only in IDLE with the serializer idle and not in reset
    assign w_grant     = (r_state == S_IDLE) && !ser_busy_i && w_found && !srst_i;
    assign w_is_drop   = (w_mod_arr[w_winner] == 4'd1) || (w_mod_arr[w_winner] == 4'd2);
    assign req_ready_o = w_grant ? (N_REQ'(1) << w_winner) : '0;

    // Next-state logic; timeout fires on the last allowed WAIT_BUSY cycle
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant && !w_is_drop) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (ser_busy_i) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == c_CNT_W'(BUSY_TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!ser_busy_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register, capture registers, pointer and busy-wait counter
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state    <= S_IDLE;
            r_ptr      <= c_ID_W'(N_REQ - 1);
            r_grant_id <= '0;
            r_data     <= '0;
            r_mod      <= '0;
            r_cnt      <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_grant && w_is_drop;
            if (w_grant) begin
                r_data     <= w_data_arr[w_winner];
                r_mod      <= w_mod_arr[w_winner];
                r_grant_id <= w_winner;
                r_ptr      <= w_winner;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT_BUSY) && !ser_busy_i) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // Combinational outputs are forced low while reset is asserted
    assign ser_data_o = r_data;
    assign ser_mod_o  = r_mod;
    assign grant_id_o = r_grant_id;
    assign ser_val_o  = (r_state == S_ISSUE) && !srst_i;
    assign active_o   = (r_state != S_IDLE) && !srst_i;
    assign drop_o     = r_drop;
    assign timeout_o  = w_timeout && !srst_i;

endmodule
`default_nettype wire

// File: tb/tb_serializer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serializer_arbiter
// Purpose  : Self-checking bench for serializer_arbiter. A transaction-level
//            model tracks pending requester words and the round-robin
//            pointer. A stub serializer drives busy with chosen rise delay
//            and length.
// Revision : 1.0  initial release
// ============================================================================
module tb_serializer_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            srst_i;
    logic [N*16-1:0] req_data_i;
    logic [N*4-1:0]  req_mod_i;
    logic [N-1:0]    req_val_i;
    logic [N-1:0]    req_ready_o;
    logic [15:0]     ser_data_o;
    logic [3:0]      ser_mod_o;
    logic            ser_val_o;
    logic            ser_busy_i;
    logic [1:0]      grant_id_o;
    logic            active_o;
    logic            drop_o;
    logic            timeout_o;

    int checks = 0;
    int errors = 0;

    // Model state: pending words per requester and last-served requester
    logic [N-1:0] pend;
    logic [15:0]  p_data [N];
    logic [3:0]   p_mod  [N];
    int           m_ptr;
    int           refill_mode;

    always #5 clk = ~clk;

    serializer_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .srst_i      (srst_i),
        .req_data_i  (req_data_i),
        .req_mod_i   (req_mod_i),
        .req_val_i   (req_val_i),
        .req_ready_o (req_ready_o),
        .ser_data_o  (ser_data_o),
        .ser_mod_o   (ser_mod_o),
        .ser_val_o   (ser_val_o),
        .ser_busy_i  (ser_busy_i),
        .grant_id_o  (grant_id_o),
        .active_o    (active_o),
        .drop_o      (drop_o),
        .timeout_o   (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input int ptr, input logic [N-1:0] mask);
        for (int i = 1; i <= N; i++) begin
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    task automatic drive_reqs();
        for (int k = 0; k < N; k++) begin
            req_data_i[k*16 +: 16] = p_data[k];
            req_mod_i[k*4 +: 4]    = p_mod[k];
            req_val_i[k]           = pend[k];
        end
    endtask

    task automatic set_req(input int k, input logic [15:0] d, input logic [3:0] m);
        pend[k]   = 1'b1;
        p_data[k] = d;
        p_mod[k]  = m;
        drive_reqs();
    endtask

    task automatic refill(input int k);
        pend[k] = 1'b0;
        if (refill_mode == 1 && $urandom_range(0, 1) == 1) begin
            set_req(k, 16'($urandom), 4'($urandom_range(0, 15)));
        end else if (refill_mode == 2) begin
            set_req(k, 16'($urandom), 4'd5);
        end
        drive_reqs();
    endtask

    // One grant: busy rises d cycles after the issue pulse and stays len
    // cycles (d > TO means it never rises); rst_at > 0 pulses reset then.
    task automatic do_txn(input int d, input int len, input int rst_at);
        int          w;
        int          fin;
        logic [15:0] ed;
        logic [3:0]  em;
        if (pend == '0) begin
            set_req($urandom_range(0, N - 1), 16'($urandom), 4'($urandom_range(0, 15)));
        end
        #1;
        w = model_winner(m_ptr, pend);
        chk("ready_onehot", 32'(req_ready_o), 32'(1) << w);
        chk("idle_val", 32'(ser_val_o), 32'd0);
        chk("idle_active", 32'(active_o), 32'd0);
        ed    = p_data[w];
        em    = p_mod[w];
        m_ptr = w;
        @(negedge clk);
        refill(w);
        ser_busy_i = 1'b0;
        #1;
        if (em == 4'd1 || em == 4'd2) begin
            chk("drop_pulse", 32'(drop_o), 32'd1);
            chk("drop_noval", 32'(ser_val_o), 32'd0);
            chk("drop_active", 32'(active_o), 32'd0);
            return;
        end
        chk("issue_val", 32'(ser_val_o), 32'd1);
        chk("issue_data", 32'(ser_data_o), 32'(ed));
        chk("issue_mod", 32'(ser_mod_o), 32'(em));
        chk("issue_grant", 32'(grant_id_o), 32'(w));
        chk("issue_active", 32'(active_o), 32'd1);
        chk("issue_ready", 32'(req_ready_o), 32'd0);
        chk("issue_drop", 32'(drop_o), 32'd0);
        fin = (d > TO) ? TO : d + len;
        for (int k = 1; k <= fin + 1; k++) begin
            @(negedge clk);
            if (rst_at != 0 && k == rst_at) begin
                srst_i = 1'b1;
                #1;
                chk("rst_ready", 32'(req_ready_o), 32'd0);
                @(negedge clk);
                srst_i     = 1'b0;
                ser_busy_i = 1'b0;
                m_ptr      = N - 1;
                #1;
                chk("rst_val", 32'(ser_val_o), 32'd0);
                chk("rst_data", 32'(ser_data_o), 32'd0);
                chk("rst_mod", 32'(ser_mod_o), 32'd0);
                chk("rst_grant", 32'(grant_id_o), 32'd0);
                chk("rst_active", 32'(active_o), 32'd0);
                chk("rst_drop", 32'(drop_o), 32'd0);
                chk("rst_timeout", 32'(timeout_o), 32'd0);
                return;
            end
            ser_busy_i = (d <= TO) && (k >= d) && (k < d + len);
            #1;
            chk("timeout", 32'(timeout_o), 32'((d > TO) && (k == TO)));
            chk("active", 32'(active_o), 32'(k <= fin));
            chk("val_once", 32'(ser_val_o), 32'd0);
            if (k <= fin) begin
                chk("busy_ready", 32'(req_ready_o), 32'd0);
                chk("hold_data", 32'(ser_data_o), 32'(ed));
                chk("hold_grant", 32'(grant_id_o), 32'(w));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pend        = '0;
        for (int k = 0; k < N; k++) begin
            p_data[k] = '0;
            p_mod[k]  = '0;
        end
        m_ptr       = N - 1;
        refill_mode = 0;
        srst_i      = 1'b1;
        ser_busy_i  = 1'b0;
        drive_reqs();

        // Reset: nothing granted even with requests pending
        repeat (2) @(negedge clk);
        set_req(1, 16'h1234, 4'd0);
        #1;
        chk("reset_ready", 32'(req_ready_o), 32'd0);
        chk("reset_val", 32'(ser_val_o), 32'd0);
        chk("reset_active", 32'(active_o), 32'd0);
        chk("reset_drop", 32'(drop_o), 32'd0);
        chk("reset_timeout", 32'(timeout_o), 32'd0);
        @(negedge clk);
        srst_i = 1'b0;
        pend   = '0;
        drive_reqs();
        #1;
        chk("post_reset_data", 32'(ser_data_o), 32'd0);
        chk("post_reset_grant", 32'(grant_id_o), 32'd0);

        // Single requester 0 with a full 16-bit word
        set_req(0, 16'hA5C3, 4'd0);
        do_txn(1, 3, 0);

        // All requesters continuously valid with mod 5: strict rotation
        refill_mode = 2;
        for (int k = 0; k < N; k++) set_req(k, 16'($urandom), 4'd5);
        repeat (8) do_txn($urandom_range(1, 3), $urandom_range(1, 3), 0);
        refill_mode = 0;
        pend = '0;
        drive_reqs();

        // Requester 2 ignored mods dropped, then requester 3 issued at once
        set_req(2, 16'hBEEF, 4'd1);
        do_txn(1, 1, 0);
        set_req(2, 16'hCAFE, 4'd2);
        do_txn(1, 1, 0);
        set_req(3, 16'h0F0F, 4'd0);
        do_txn(2, 2, 0);

        // Busy never rises: timeout, then the next requester is served
        set_req(1, 16'h1111, 4'd7);
        set_req(2, 16'h2222, 4'd3);
        do_txn(TO + 5, 0, 0);
        do_txn(1, 2, 0);

        // Serializer busy while idle blocks any grant
        set_req(0, 16'h00AA, 4'd0);
        set_req(1, 16'h00BB, 4'd0);
        ser_busy_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("busy_idle_ready", 32'(req_ready_o), 32'd0);
            @(negedge clk);
        end
        ser_busy_i = 1'b0;
        do_txn(1, 2, 0);
        do_txn(1, 1, 0);

        // Reset pulsed in WAIT_DONE; requester 0 then wins first
        set_req(2, 16'h5A5A, 4'd0);
        do_txn(1, 4, 3);
        set_req(1, 16'h7777, 4'd0);
        set_req(0, 16'h6666, 4'd0);
        set_req(3, 16'h8888, 4'd0);
        #1;
        chk("post_rst_winner", 32'(req_ready_o), 32'd1);
        do_txn(1, 1, 0);
        pend = '0;
        drive_reqs();

        // Randomized traffic against the model
        refill_mode = 1;
        for (int t = 0; t < 40; t++) begin
            do_txn($urandom_range(1, TO + 2), $urandom_range(1, 4), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
